// File: rtl/game_flow_ctrl_if.sv
// Handshake bundle between the game-flow controller and the menu/script/player/compositor blocks.
// The slave modport is the controller's view; master is the surrounding system's view.
interface game_flow_ctrl_if #(
    parameter int unsigned LVL_W = 4
);
    logic             start;
    logic [LVL_W-1:0] start_level;
    logic             gameend;
    logic             fail;
    logic             ret;
    logic             pause;
    logic [2:0]       state;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] max_unlocked;
    logic             level_start;
    logic             reject;

    modport master (
        output start, start_level, gameend, fail, ret, pause,
        input  state, level, max_unlocked, level_start, reject
    );

    modport slave (
        input  start, start_level, gameend, fail, ret, pause,
        output state, level, max_unlocked, level_start, reject
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Multi-level game-flow FSM: menu, play, clear, failure and victory scenes with level unlocking.
// Optional pause scene is built when GAME_FLOW_PAUSE_EN is defined.
module game_flow_ctrl #(
    parameter int unsigned NUM_LEVELS   = 4,
    parameter int unsigned LVL_W        = 4,
    parameter int unsigned CLEAR_HOLD   = 64,
    parameter int unsigned FAIL_TIMEOUT = 0
) (
    input logic               clk,
    input logic               rst,
    game_flow_ctrl_if.slave   bus
);
    localparam int unsigned TMax   = (CLEAR_HOLD > FAIL_TIMEOUT) ?
                                     ((CLEAR_HOLD > 2) ? CLEAR_HOLD : 2) :
                                     ((FAIL_TIMEOUT > 2) ? FAIL_TIMEOUT : 2);
    localparam int unsigned TimerW = $clog2(TMax) + 1;

    localparam logic [LVL_W-1:0]  LastLvl   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [TimerW-1:0] ClearLast = TimerW'(CLEAR_HOLD - 1);
    localparam logic [TimerW-1:0] FailLast  = TimerW'(FAIL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StMenu    = 3'd0,
        StPlay    = 3'd1,
        StPause   = 3'd2,
        StClear   = 3'd3,
        StFailure = 3'd4,
        StVictory = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [LVL_W-1:0]   max_q, max_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               level_start_q, level_start_d;
    logic               reject_q, reject_d;
    logic [LVL_W-1:0]   level_inc;

    assign level_inc = level_q + LVL_W'(1);

`ifndef GAME_FLOW_PAUSE_EN
    logic unused_pause;
    assign unused_pause = bus.pause;
`endif

    always_comb begin
        state_d       = state_q;
        level_d       = level_q;
        max_d         = max_q;
        timer_d       = timer_q;
        level_start_d = 1'b0;
        reject_d      = 1'b0;
        case (state_q)
            StMenu: begin
                if (bus.start) begin
                    if (bus.start_level <= max_q && bus.start_level <= LastLvl) begin
                        level_d       = bus.start_level;
                        state_d       = StPlay;
                        level_start_d = 1'b1;
                        timer_d       = '0;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            StPlay: begin
                if (bus.fail) begin
                    state_d = StFailure;
                    timer_d = '0;
                end else if (bus.gameend) begin
                    state_d = StClear;
                    timer_d = '0;
                    if (level_q != LastLvl && level_inc > max_q) begin
                        max_d = level_inc;
                    end
`ifdef GAME_FLOW_PAUSE_EN
                end else if (bus.pause) begin
                    state_d = StPause;
                    timer_d = '0;
`endif
                end
            end
`ifdef GAME_FLOW_PAUSE_EN
            StPause: begin
                if (bus.ret) begin
                    state_d = StMenu;
                    timer_d = '0;
                end else if (bus.pause) begin
                    // Resuming the same level, so no level_start pulse.
                    state_d = StPlay;
                    timer_d = '0;
                end
            end
`endif
            StClear: begin
                if (timer_q == ClearLast) begin
                    timer_d = '0;
                    if (level_q == LastLvl) begin
                        state_d = StVictory;
                    end else begin
                        level_d       = level_inc;
                        state_d       = StPlay;
                        level_start_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StFailure: begin
                if (bus.ret) begin
                    state_d = StMenu;
                    timer_d = '0;
                end else if (FAIL_TIMEOUT != 0) begin
                    if (timer_q == FailLast) begin
                        state_d = StMenu;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
            end
            StVictory: begin
                if (bus.ret) begin
                    state_d = StMenu;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = StMenu;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StMenu;
            level_q       <= '0;
            max_q         <= '0;
            timer_q       <= '0;
            level_start_q <= 1'b0;
            reject_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            max_q         <= max_d;
            timer_q       <= timer_d;
            level_start_q <= level_start_d;
            reject_q      <= reject_d;
        end
    end

    assign bus.state        = state_q;
    assign bus.level        = level_q;
    assign bus.max_unlocked = max_q;
    assign bus.level_start  = level_start_q;
    assign bus.reject       = reject_q;
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Parametrised top-level game-flow FSM that sequences menu, play, clear, failure and victory scenes across NUM_LEVELS difficulty levels. It replaces the fixed single-level state register in the top module. Inputs come from the menu, script, player and failure-screen blocks. Its state code drives the pixel compositor, and its level index drives the script and player blocks. Unlike the fixed version, it adds level unlocking, timed auto-advance between levels, a victory scene and an optional failure timeout.

Parameters:
NUM_LEVELS, 4, number of playable levels (2..16)
LVL_W, 4, width of level index; must satisfy 2**LVL_W >= NUM_LEVELS
CLEAR_HOLD, 64, cycles spent in CLEAR before advancing (>=1)
FAIL_TIMEOUT, 0, cycles in FAILURE before auto-return to MENU; 0 disables timeout

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse from menu: request to begin play
start_level  in  LVL_W  level requested with start
gameend  in  1  level script finished (level pulse/level, sampled in PLAY)
fail  in  1  player life exhausted (sampled in PLAY)
ret  in  1  one-cycle pulse: return key on FAILURE/VICTORY screen
pause  in  1  one-cycle pulse: pause toggle (used only with the optional feature)
state  out  3  scene code: 0 MENU, 1 PLAY, 2 PAUSE, 3 CLEAR, 4 FAILURE, 5 VICTORY
level  out  LVL_W  current level index
max_unlocked  out  LVL_W  highest selectable level
level_start  out  1  one-cycle pulse on every entry to PLAY from MENU or CLEAR
reject  out  1  one-cycle pulse when a start request is refused

Behaviour:
- Reset values: state=MENU, level=0, max_unlocked=0, level_start=0, reject=0, internal timer=0. A reset mid-game returns to MENU on the next edge and also clears unlock progress.
- All outputs are registered. state changes one cycle after the qualifying input is high at a clk edge.
- MENU:
  - start with start_level <= max_unlocked: load level=start_level, go to PLAY, pulse level_start in the same cycle state becomes PLAY.
  - start with start_level > max_unlocked, or start_level >= NUM_LEVELS: stay in MENU, pulse reject, level unchanged.
- PLAY:
  - fail=1: go to FAILURE. fail has priority over a simultaneous gameend.
  - else gameend=1: go to CLEAR. Timer loads 0.
  - If level < NUM_LEVELS-1 and level+1 > max_unlocked, max_unlocked <= level+1. The unlock happens on the CLEAR entry edge.
- CLEAR:
  - The timer counts up each cycle. When timer == CLEAR_HOLD-1, leave CLEAR.
  - If level == NUM_LEVELS-1, go to VICTORY.
  - Otherwise set level <= level+1, go to PLAY and pulse level_start.
  - fail, gameend, start and ret are ignored in CLEAR.
- FAILURE:
  - ret goes to MENU.
  - If FAIL_TIMEOUT != 0, the timer counts from 0. At timer == FAIL_TIMEOUT-1 the block goes to MENU even without ret.
  - ret and timeout in the same cycle give a single transition to MENU.
  - level is held until the next start.
- VICTORY: ret goes to MENU. There is no timeout.
- Timer: width ceil(log2(max(CLEAR_HOLD, FAIL_TIMEOUT, 2)))+1. It is cleared on every state entry and never wraps within a state.
- start is ignored outside MENU. ret is ignored outside FAILURE and VICTORY.
- level never exceeds NUM_LEVELS-1. max_unlocked is monotonic until reset.
- Unused state codes 6 and 7 recover to MENU on the next edge.

Optional Feature:
GAME_FLOW_PAUSE_EN
- Defined:
  - A pause pulse in PLAY goes to PAUSE. A pause pulse in PAUSE returns to PLAY, and level_start is NOT pulsed.
  - ret in PAUSE abandons the level and goes to MENU.
  - gameend and fail are ignored in PAUSE.
  - pause simultaneous with fail in PLAY: fail wins.
- Undefined: the pause input is ignored, and the PAUSE code (2) is never produced.

Test Plan:
All scenarios use NUM_LEVELS=4, CLEAR_HOLD=4, FAIL_TIMEOUT=8.
- Reset then start with start_level=2 -> reject pulses 1 cycle, state stays 0, level=0. Then start with start_level=0 -> state=1, level=0, level_start pulses once.
- In PLAY level 0, pulse gameend -> state=3, max_unlocked=1. Exactly 4 cycles later -> state=1, level=1, level_start pulse.
- In PLAY, assert fail and gameend together -> state=4, max_unlocked unchanged. Hold ret low -> state=0 exactly 8 cycles after FAILURE entry.
- Clear all levels 0..3 in sequence -> after the last CLEAR hold, state=5, level=3, max_unlocked=3. Then pulse ret -> state=0.
- Assert rst for one cycle while in CLEAR at timer=2 -> next cycle state=0, level=0, max_unlocked=0, no level_start pulse.
- With GAME_FLOW_PAUSE_EN defined: pause in PLAY -> state=2. gameend while paused -> no change. pause again -> state=1 with no level_start pulse. Without the macro: pause -> state stays 1.
